// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage -- elastic pipeline register with a 2-entry skid buffer.
//
// This stage sits at a core stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
// in_ready is a flop, so there is no combinational path from out_ready back
// to the upstream stage. A synchronous flush drops every held entry and any
// payload offered in the same cycle. occ reports the number of held entries
// to the hazard logic.
//
// Optional feature: define PIPE_SKID_PERF_EN to add the CNT_W parameter and
// the stall_cnt and bubble_cnt saturating performance counters. The default
// build leaves the macro undefined.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_EMPTY | nothing held; out_valid=0, in_ready=1, occ=0
// S_ONE   | main register valid; in_ready=1, occ=1
// S_TWO   | main and skid registers valid; in_ready=0, occ=2

module pipe_skid_stage #(
   parameter int                DATA_W   = 32,
   parameter logic [DATA_W-1:0] RST_DATA = '0
`ifdef PIPE_SKID_PERF_EN
   ,
   parameter int                CNT_W    = 16
`endif
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occ
`ifdef PIPE_SKID_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
`endif
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_nxt;
   logic              in_ready_q;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] skid_q;

   logic              in_fire;
   logic              out_fire;
   logic              load_main_in;
   logic              load_main_skid;
   logic              load_skid;

   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = out_valid & out_ready;

   // State register. Reset is asynchronous, so both entries are dropped at once.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_EMPTY;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next-state logic. Flush wins over any simultaneous in_fire or out_fire.
   always_comb begin
      state_nxt = state_q;
      if (flush) begin
         state_nxt = S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (in_fire) begin
                  state_nxt = S_ONE;
               end
            end
            S_ONE: begin
               if (in_fire && !out_ready) begin
                  state_nxt = S_TWO;
               end else if (out_fire && !in_fire) begin
                  state_nxt = S_EMPTY;
               end
            end
            S_TWO: begin
               if (out_fire) begin
                  state_nxt = S_ONE;
               end
            end
            default: begin
               state_nxt = S_EMPTY;
            end
         endcase
      end
   end

   // Output decode and data-path load enables. A flush suppresses every capture.
   always_comb begin
      out_valid      = 1'b0;
      occ            = 2'd0;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state_q)
         S_EMPTY: begin
            out_valid    = 1'b0;
            occ          = 2'd0;
            load_main_in = in_fire & ~flush;
         end
         S_ONE: begin
            out_valid    = 1'b1;
            occ          = 2'd1;
            load_main_in = in_fire & out_fire & ~flush;
            load_skid    = in_fire & ~out_ready & ~flush;
         end
         S_TWO: begin
            out_valid      = 1'b1;
            occ            = 2'd2;
            load_main_skid = out_fire & ~flush;
         end
         default: begin
            out_valid = 1'b0;
            occ       = 2'd0;
         end
      endcase
   end

   // in_ready is registered from the next state only, so out_ready never
   // reaches it combinationally.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         in_ready_q <= 1'b1;
      end else begin
         in_ready_q <= (state_nxt != S_TWO);
      end
   end

   assign in_ready = in_ready_q;

   // Main and skid data registers. Flush does not clear them; only the valid
   // state is dropped.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         main_q <= RST_DATA;
         skid_q <= RST_DATA;
      end else begin
         if (load_main_in) begin
            main_q <= in_data;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_data;
         end
      end
   end

   assign out_data = main_q;

`ifdef PIPE_SKID_PERF_EN
   // Backpressure counter. It saturates, clears only on reset and ignores flush.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   // Empty-output counter. It saturates, clears only on reset and ignores flush.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bubble_cnt <= '0;
      end else if (!out_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
         bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Testbench for pipe_skid_stage: directed scenarios plus random traffic,
// all checked against a queue-based model of the held entries.

module tb_pipe_skid_stage;

   localparam int       DW   = 8;
   localparam logic [7:0] RSTD = 8'h5A;
`ifdef PIPE_SKID_PERF_EN
   localparam int       CW   = 4;
   localparam int       CMAX = (1 << CW) - 1;
`endif

   logic          clk       = 1'b0;
   logic          rstn      = 1'b0;
   logic          flush     = 1'b0;
   logic          in_valid  = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] in_data   = '0;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [1:0]    occ;
`ifdef PIPE_SKID_PERF_EN
   logic [CW-1:0] stall_cnt;
   logic [CW-1:0] bubble_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   logic [DW-1:0] mq[$];
   int            m_stall  = 0;
   int            m_bubble = 0;

   always #5 clk = ~clk;

`ifdef PIPE_SKID_PERF_EN
   pipe_skid_stage #(.DATA_W(DW), .RST_DATA(RSTD), .CNT_W(CW)) dut (
      .clk(clk), .rstn(rstn), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occ(occ), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
   );
`else
   pipe_skid_stage #(.DATA_W(DW), .RST_DATA(RSTD)) dut (
      .clk(clk), .rstn(rstn), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occ(occ)
   );
`endif

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
   endtask

   task automatic check_model();
      chk("out_valid", out_valid, mq.size() > 0);
      chk("occ", occ, mq.size());
      chk("in_ready", in_ready, mq.size() < 2);
      if (mq.size() > 0) chk("out_data", out_data, mq[0]);
      if (occ == 2'd2) chk("in_ready_at_occ2", in_ready, 1'b0);
`ifdef PIPE_SKID_PERF_EN
      chk("stall_cnt", stall_cnt, m_stall);
      chk("bubble_cnt", bubble_cnt, m_bubble);
`endif
   endtask

   // One clock: the model consumes the same inputs the DUT sees at the edge.
   task automatic cycle();
      bit ov;
      bit ir;
      @(posedge clk);
      ov = (mq.size() > 0);
      ir = (mq.size() < 2);
      if (ov && !out_ready && m_stall < 65535) m_stall++;
      if (!ov && m_bubble < 65535) m_bubble++;
`ifdef PIPE_SKID_PERF_EN
      if (m_stall > CMAX) m_stall = CMAX;
      if (m_bubble > CMAX) m_bubble = CMAX;
`endif
      if (flush) begin
         mq.delete();
      end else begin
         if (ov && out_ready) void'(mq.pop_front());
         if (in_valid && ir) mq.push_back(in_data);
      end
      #1;
      check_model();
   endtask

   task automatic do_reset();
      drive(1'b0, '0, 1'b0, 1'b0);
      @(negedge clk);
      rstn = 1'b0;
      mq.delete();
      m_stall  = 0;
      m_bubble = 0;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_occ", occ, 2'd0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_data", out_data, RSTD);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      do_reset();

      // basic flow at full throughput
      drive(1'b1, 8'h11, 1'b1, 1'b0); cycle();
      chk("basic_d0", out_data, 8'h11); chk("basic_occ0", occ, 2'd1); chk("basic_rdy0", in_ready, 1'b1);
      drive(1'b1, 8'h22, 1'b1, 1'b0); cycle();
      chk("basic_d1", out_data, 8'h22); chk("basic_occ1", occ, 2'd1); chk("basic_rdy1", in_ready, 1'b1);
      drive(1'b1, 8'h33, 1'b1, 1'b0); cycle();
      chk("basic_d2", out_data, 8'h33); chk("basic_occ2", occ, 2'd1); chk("basic_rdy2", in_ready, 1'b1);
      drive(1'b0, 8'h00, 1'b1, 1'b0); cycle();
      chk("basic_drained", out_valid, 1'b0);

      // backpressure fills the skid entry, then drains in order
      drive(1'b1, 8'h0A, 1'b0, 1'b0); cycle();
      drive(1'b1, 8'h0B, 1'b0, 1'b0); cycle();
      chk("bp_occ", occ, 2'd2); chk("bp_rdy", in_ready, 1'b0); chk("bp_data", out_data, 8'h0A);
      drive(1'b1, 8'hEE, 1'b0, 1'b0); cycle();
      chk("bp_hold", out_data, 8'h0A); chk("bp_hold_occ", occ, 2'd2);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      #1 chk("bp_first", out_data, 8'h0A);
      cycle();
      chk("bp_second", out_data, 8'h0B); chk("bp_second_v", out_valid, 1'b1);
      cycle();
      chk("bp_empty", out_valid, 1'b0);

      // flush from two held entries with a payload offered in the same cycle
      drive(1'b1, 8'h0A, 1'b0, 1'b0); cycle();
      drive(1'b1, 8'h0B, 1'b0, 1'b0); cycle();
      drive(1'b1, 8'h0C, 1'b0, 1'b1); cycle();
      chk("fl_valid", out_valid, 1'b0); chk("fl_occ", occ, 2'd0); chk("fl_rdy", in_ready, 1'b1);
      chk("fl_data_kept", out_data, 8'h0A);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("fl_no_0c", out_valid, 1'b0);
      end

      // asynchronous reset while two entries are held
      drive(1'b1, 8'h31, 1'b0, 1'b0); cycle();
      drive(1'b1, 8'h32, 1'b0, 1'b0); cycle();
      chk("ar_pre_occ", occ, 2'd2);
      #2 rstn = 1'b0;
      #1;
      chk("ar_valid", out_valid, 1'b0); chk("ar_occ", occ, 2'd0);
      chk("ar_rdy", in_ready, 1'b1); chk("ar_data", out_data, RSTD);
      mq.delete();
      m_stall  = 0;
      m_bubble = 0;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      rstn = 1'b1;

`ifdef PIPE_SKID_PERF_EN
      do_reset();
      drive(1'b1, 8'h40, 1'b0, 1'b0); cycle();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cycle();
      chk("perf_stall5", stall_cnt, 5);
      drive(1'b0, 8'h00, 1'b1, 1'b0); cycle();
      for (int i = 0; i < 20; i++) cycle();
      chk("perf_bubble_sat", bubble_cnt, CMAX);
      chk("perf_stall_hold", stall_cnt, 5);
`endif

      // random traffic with varying backpressure and occasional flush
      for (int i = 0; i < 10000; i++) begin
         logic iv;
         logic ordy;
         logic fl;
         iv   = ($urandom_range(0, 3) != 0);
         ordy = (i % 2000 < 1000) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
         fl   = ($urandom_range(0, 63) == 0);
         drive(iv, DW'($urandom), ordy, fl);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
